// File: rtl/jcnt_pkg.sv
// ============================================================================
// jcnt_pkg : shared types, limits and the phase-to-pattern decode function
//            for the Johnson counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package jcnt_pkg;

    localparam int MAX_WIDTH = 16;

    typedef enum logic {
        JCNT_DN = 1'b0,
        JCNT_UP = 1'b1
    } jcnt_dir_t;

    // Phase p <= width fills the low p bits; beyond that the ones drain from the bottom.
    function automatic logic [MAX_WIDTH-1:0] phase_to_pattern(input int width, input int phase);
        logic [MAX_WIDTH-1:0] pat;
        pat = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (i < width) begin
                if (phase <= width) begin
                    pat[i] = (i < phase);
                end else begin
                    pat[i] = (i >= (phase - width));
                end
            end
        end
        return pat;
    endfunction

endpackage

`default_nettype wire

// File: rtl/jcnt_pattern_gen.sv
// ============================================================================
// jcnt_pattern_gen : combinational decoder from phase index to the Johnson
//                    pattern of that phase.
// Revision : 1.0
// ============================================================================
`default_nettype none

module jcnt_pattern_gen
    import jcnt_pkg::*;
#(
    parameter int WIDTH   = 3,
    parameter int PHASE_W = $clog2(2*WIDTH)
) (
    input  logic [PHASE_W-1:0] i_phase,
    output logic [WIDTH-1:0]   o_pattern
);

    assign o_pattern = WIDTH'(phase_to_pattern(WIDTH, int'(i_phase)));

endmodule

`default_nettype wire

// File: rtl/johnson_counter_gen.sv
// ============================================================================
// johnson_counter_gen : parametrised Johnson counter with enable, direction,
//                       clear, phase load, wrap pulse and illegal-state flag.
//                       Macro JCNT_SELF_CORRECT_EN enables auto-recovery.
// Revision : 1.0
// ============================================================================
`default_nettype none

module johnson_counter_gen
    import jcnt_pkg::*;
#(
    parameter int WIDTH   = 3,
    parameter int PHASE_W = $clog2(2*WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_en,
    input  logic               i_up,
    input  logic               i_clr,
    input  logic               i_load,
    input  logic [PHASE_W-1:0] i_load_phase,
    output logic [WIDTH-1:0]   o_count,
    output logic [PHASE_W-1:0] o_phase,
    output logic               o_wrap,
    output logic               o_illegal
);

    localparam logic [PHASE_W-1:0] c_LAST  = PHASE_W'(2*WIDTH - 1);
    localparam logic [PHASE_W-1:0] c_FIRST = '0;

    logic [WIDTH-1:0]   r_count;
    logic [PHASE_W-1:0] r_phase;
    logic               r_wrap;

    logic [WIDTH-1:0]   w_load_pat;
    logic [WIDTH-1:0]   w_exp_pat;
    logic               w_load_ok;
    logic               w_illegal;
    jcnt_dir_t          w_dir;
    logic [WIDTH-1:0]   w_fwd_count;
    logic [WIDTH-1:0]   w_rev_count;
    logic [PHASE_W-1:0] w_fwd_phase;
    logic [PHASE_W-1:0] w_rev_phase;

    jcnt_pattern_gen #(
        .WIDTH   (WIDTH),
        .PHASE_W (PHASE_W)
    ) u_load_pat (
        .i_phase   (i_load_phase),
        .o_pattern (w_load_pat)
    );

    jcnt_pattern_gen #(
        .WIDTH   (WIDTH),
        .PHASE_W (PHASE_W)
    ) u_exp_pat (
        .i_phase   (r_phase),
        .o_pattern (w_exp_pat)
    );

    assign w_load_ok   = (i_load_phase <= c_LAST);
    assign w_illegal   = (r_count != w_exp_pat);
    assign w_dir       = jcnt_dir_t'(i_up);

    assign w_fwd_count = {r_count[WIDTH-2:0], ~r_count[WIDTH-1]};
    assign w_rev_count = {~r_count[0], r_count[WIDTH-1:1]};
    assign w_fwd_phase = (r_phase == c_LAST)  ? c_FIRST : r_phase + PHASE_W'(1);
    assign w_rev_phase = (r_phase == c_FIRST) ? c_LAST  : r_phase - PHASE_W'(1);

    // An out-of-range load still claims the cycle, so en is not applied behind it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_phase <= '0;
            r_wrap  <= 1'b0;
        end else if (i_clr) begin
            r_count <= '0;
            r_phase <= '0;
            r_wrap  <= 1'b0;
`ifdef JCNT_SELF_CORRECT_EN
        end else if (w_illegal) begin
            r_count <= '0;
            r_phase <= '0;
            r_wrap  <= 1'b0;
`endif
        end else if (i_load) begin
            r_wrap <= 1'b0;
            if (w_load_ok) begin
                r_count <= w_load_pat;
                r_phase <= i_load_phase;
            end
        end else if (i_en) begin
            if (w_dir == JCNT_UP) begin
                r_count <= w_fwd_count;
                r_phase <= w_fwd_phase;
                r_wrap  <= (r_phase == c_LAST);
            end else begin
                r_count <= w_rev_count;
                r_phase <= w_rev_phase;
                r_wrap  <= (r_phase == c_FIRST);
            end
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign o_count   = r_count;
    assign o_phase   = r_phase;
    assign o_wrap    = r_wrap;
    assign o_illegal = w_illegal;

endmodule

`default_nettype wire
